// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI slave front end and the RAM behind it.
package spi_mem_pkg;

    // Slave FSM states
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    // Command field values carried in the two MSBs of every frame
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-in serial-out shifter that drives MISO with a RAM read word, MSB first.
// After one word it reports done and refuses to reload until cleared.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_miso;
    logic              r_busy;
    logic              r_done;

    // Load presents the MSB at once; the remaining bits follow one per clock, then MISO returns low
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_miso  <= r_shift[DATA_W-1];
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_cnt   <= r_cnt - 1'b1;
            end
        end else if (i_load && !r_done) begin
            r_shift <= {i_data[DATA_W-2:0], 1'b0};
            r_miso  <= i_data[DATA_W-1];
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_busy  <= 1'b1;
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for the RAM: collects 10-bit command frames from MOSI and
// returns RAM read data on MISO after a read-data frame.
module spi_slave
    import spi_mem_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W);

    state_t             r_state;
    logic [FRAME_W-1:0] r_rxShift;
    logic [FRAME_W-1:0] r_rxData;
    logic               r_rxValid;
    logic [CNT_W-1:0]   r_bitCnt;
    logic               r_frameDone;
    logic               r_rdAddrDone;

    logic w_inPayload;
    logic w_lastBit;
    logic w_txLoad;
    logic w_txBusy;
    logic w_txDone;

    // The payload states share the same sampling path; the frame ends on the edge that samples bit 0
    assign w_inPayload = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
    assign w_lastBit   = w_inPayload && !r_frameDone && (r_bitCnt == CNT_W'(FRAME_W - 1));
    assign w_txLoad    = (r_state == READ_DATA) && r_frameDone && tx_valid && !SS_n
                         && !w_txBusy && !w_txDone;

    // Frame FSM, receive shift register, bit counter and the read-address handshake flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rxShift    <= '0;
            r_rxData     <= '0;
            r_rxValid    <= 1'b0;
            r_bitCnt     <= '0;
            r_frameDone  <= 1'b0;
            r_rdAddrDone <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            if (w_lastBit) begin
                r_rxData    <= {r_rxShift[FRAME_W-2:0], MOSI};
                r_rxValid   <= 1'b1;
                r_frameDone <= 1'b1;
                if (r_state == READ_ADD) begin
                    r_rdAddrDone <= 1'b1;
                end else if (r_state == READ_DATA) begin
                    r_rdAddrDone <= 1'b0;
                end
            end
            if (SS_n && (r_state != IDLE)) begin
                r_state     <= IDLE;
                r_bitCnt    <= '0;
                r_frameDone <= 1'b0;
                r_rxShift   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!SS_n) begin
                            r_state     <= CHK_CMD;
                            r_bitCnt    <= '0;
                            r_frameDone <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        r_rxShift <= {r_rxShift[FRAME_W-2:0], MOSI};
                        r_bitCnt  <= CNT_W'(1);
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rdAddrDone) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frameDone) begin
                            r_rxShift <= {r_rxShift[FRAME_W-2:0], MOSI};
                            if (!w_lastBit) begin
                                r_bitCnt <= r_bitCnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_txShifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (SS_n),
        .i_load  (w_txLoad),
        .i_data  (tx_data),
        .o_miso  (MISO),
        .o_busy  (w_txBusy),
        .o_done  (w_txDone)
    );

    assign rx_data  = r_rxData;
    assign rx_valid = r_rxValid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave; the bench plays the SPI master and the RAM answer.
module tb_spi_slave;
    import spi_mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    spi_slave #(
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // 10 ns SPI clock
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the master pins, then move to just after the next rising edge
    task automatic applyStimulus(input logic ss, input logic mosi);
        SS_n = ss;
        MOSI = mosi;
        @(posedge clk);
        #1;
    endtask

    // Full frame with SS_n held low; SS_n stays low afterwards
    task automatic sendFrame(input logic [9:0] f, input string tag);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_chk"}, 16'(dut.r_state), 16'(CHK_CMD));
        for (int i = 9; i >= 0; i--) begin
            applyStimulus(1'b0, f[i]);
            if (i == 1) checkOutput({tag, "_vld_early"}, 16'(rx_valid), 16'h0);
        end
        checkOutput({tag, "_vld"}, 16'(rx_valid), 16'h1);
        checkOutput({tag, "_data"}, 16'(rx_data), 16'(f));
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_vld_off"}, 16'(rx_valid), 16'h0);
    endtask

    task automatic endFrame(input string tag);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, "_idle"}, 16'(dut.r_state), 16'(IDLE));
        checkOutput({tag, "_miso"}, 16'(MISO), 16'h0);
    endtask

    initial begin
        logic [7:0] txExp;
        logic [9:0] frm;
        rst_n    = 1'b0;
        SS_n     = 1'b0;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;

        // Reset with SS_n low and MOSI toggling
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_miso", 16'(MISO), 16'h0);
        checkOutput("rst_vld", 16'(rx_valid), 16'h0);
        checkOutput("rst_data", 16'(rx_data), 16'h0);
        checkOutput("rst_state", 16'(dut.r_state), 16'(IDLE));
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rel_state", 16'(dut.r_state), 16'(IDLE));

        // Write address then write data
        sendFrame(10'h001, "wa");
        checkOutput("wa_state", 16'(dut.r_state), 16'(WRITE));
        endFrame("wa");
        sendFrame(10'h132, "wd");
        endFrame("wd");

        // Read address then read data with the RAM answering 0x32
        sendFrame(10'h201, "ra");
        checkOutput("ra_state", 16'(dut.r_state), 16'(READ_ADD));
        checkOutput("ra_flag", 16'(dut.r_rdAddrDone), 16'h1);
        endFrame("ra");
        sendFrame(10'h3A5, "rd");
        checkOutput("rd_state", 16'(dut.r_state), 16'(READ_DATA));
        checkOutput("rd_flag", 16'(dut.r_rdAddrDone), 16'h0);
        checkOutput("rd_miso_wait", 16'(MISO), 16'h0);
        txExp    = 8'h32;
        tx_data  = txExp;
        tx_valid = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("rd_miso7", 16'(MISO), 16'(txExp[7]));
        tx_data = 8'hFF;
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("rd_miso%0d", i), 16'(MISO), 16'(txExp[i]));
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("rd_miso_tail0", 16'(MISO), 16'h0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rd_miso_tail1", 16'(MISO), 16'h0);
        tx_valid = 1'b0;
        endFrame("rd");

        // Alternating read-address / read-data decode
        sendFrame(10'h2AA, "alt1");
        checkOutput("alt1_state", 16'(dut.r_state), 16'(READ_ADD));
        endFrame("alt1");
        sendFrame(10'h3FF, "alt2");
        checkOutput("alt2_state", 16'(dut.r_state), 16'(READ_DATA));
        endFrame("alt2");
        sendFrame(10'h255, "alt3");
        checkOutput("alt3_state", 16'(dut.r_state), 16'(READ_ADD));
        endFrame("alt3");

        // Abort a write frame after five bits
        frm = 10'h0F0;
        applyStimulus(1'b0, 1'b0);
        for (int i = 9; i >= 5; i--) applyStimulus(1'b0, frm[i]);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_state", 16'(dut.r_state), 16'(IDLE));
        checkOutput("abort_vld", 16'(rx_valid), 16'h0);
        checkOutput("abort_data", 16'(rx_data), 16'h255);
        checkOutput("abort_flag", 16'(dut.r_rdAddrDone), 16'h1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_vld2", 16'(rx_valid), 16'h0);
        sendFrame(10'h1A5, "after");
        endFrame("after");

        // SS_n rises on the edge that samples bit 0
        frm = 10'h0C3;
        applyStimulus(1'b0, 1'b0);
        for (int i = 9; i >= 1; i--) applyStimulus(1'b0, frm[i]);
        applyStimulus(1'b1, frm[0]);
        checkOutput("edge_vld", 16'(rx_valid), 16'h1);
        checkOutput("edge_data", 16'(rx_data), 16'h0C3);
        checkOutput("edge_state", 16'(dut.r_state), 16'(IDLE));
        applyStimulus(1'b1, 1'b0);
        checkOutput("edge_vld_off", 16'(rx_valid), 16'h0);

        // SS_n rises in the middle of a MISO shift
        sendFrame(10'h3C0, "mid");
        checkOutput("mid_state", 16'(dut.r_state), 16'(READ_DATA));
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_miso7", 16'(MISO), 16'h1);
        tx_valid = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_miso6", 16'(MISO), 16'h1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_miso_cut", 16'(MISO), 16'h0);
        checkOutput("mid_idle", 16'(dut.r_state), 16'(IDLE));
        checkOutput("mid_flag", 16'(dut.r_rdAddrDone), 16'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
